// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//                NOP_INSTR is the canonical RISC-V NOP (addi x0, x0, 0)
//                shown to decode whenever the fetch buffer is empty.
//                fetch_entry_t is one buffered {pc, instr} pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of DEPTH entries (power of two, >= 2) with
//                push/pop/flush, full/empty flags and head data.
//                Flush empties the FIFO and resets both pointers; it
//                overrides push and pop in the same cycle.
//  Ports       : clk, rst_n (async active-low)
//                push, wr_data   - write wr_data at tail
//                pop             - advance head
//                flush           - discard all entries
//                head_data       - entry at head (meaningful when !empty)
//                full, empty     - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t
)(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic flush,
   input  T     wr_data,
   output T     head_data,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("fetch_fifo: DEPTH must be a power of two and at least 2");
      end
   endgenerate

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   T              mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign head_data = mem[head];

   // Guard against misuse: never pop an empty FIFO, and only push into a
   // full FIFO when an entry leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop)  head <= head + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observable while counted.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[tail] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the PC, addresses instruction
//                memory combinationally, buffers {pc, instr} pairs in a
//                DEPTH-entry FIFO and hands them to decode over valid/ready.
//                A redirect flushes the buffer and restarts the PC at the
//                word-aligned target.
//  Ports       : clk, rst_n (async active-low)
//                imem_addr  (out 32) / imem_rdata (in 32)  - instruction memory
//                redirect_valid, redirect_pc (in)          - branch/jump target
//                dec_valid, dec_instr, dec_pc, dec_pc_plus4 (out), dec_ready (in)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_instr,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_pc_plus4
);

   logic [31:0]  pc;
   logic         push;
   logic         pop;
   logic         full;
   logic         empty;
   fetch_entry_t wr_entry;
   fetch_entry_t head_entry;

   assign imem_addr = pc;

   assign dec_valid = ~empty;
   assign pop       = dec_valid & dec_ready;
   // A full buffer can still accept a fetch when decode drains one this cycle.
   assign push      = ~redirect_valid & (~full | pop);

   assign wr_entry.pc    = pc;
   assign wr_entry.instr = imem_rdata;

   // Redirect wins over everything; misaligned low bits are simply dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc & ~32'h0000_0003;
      end else if (push) begin
         pc <= pc + 32'd4;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .wr_data   (wr_entry),
      .head_data (head_entry),
      .full      (full),
      .empty     (empty)
   );

   // Present a clean NOP at address 0 when empty so no stale data leaks out.
   assign dec_instr    = empty ? NOP_INSTR : head_entry.instr;
   assign dec_pc       = empty ? 32'h0     : head_entry.pc;
   assign dec_pc_plus4 = dec_pc + 32'd4;

endmodule
`default_nettype wire
